// File: rtl/mp64_fp_add_pipe_if.sv
// mp64_fp_add_pipe_if: operand/result handshake bundle for the pipelined FP adder.
// master drives in_valid/a/b/op_sub/out_ready; slave drives in_ready/out_valid/result/flags.
interface mp64_fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, flags
  );
  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/mp64_fp_add_pipe.sv
// mp64_fp_add_pipe: 3-stage pipelined FP add/sub, round-to-nearest-even, flush-to-zero.
// Ports: clk, rst (async, active-high), bus (slave: in_valid/in_ready/a/b/op_sub in,
// out_valid/out_ready/result/flags out; flags = {invalid, overflow, underflow, inexact}).
module mp64_fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  mp64_fp_add_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;
  localparam int N = MAN_W + 5;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic en;
  logic v1_q, spc1_q, inv1_q, s1_q, sub1_q;
  logic [W-1:0] sres1_q;
  logic [EXP_W-1:0] e1_q;
  logic [F-1:0] fx1_q, fy1_q;
  logic v2_q, spc2_q, inv2_q, s2_q, sub2_q;
  logic [W-1:0] sres2_q;
  logic [EXP_W-1:0] e2_q;
  logic [N-1:0] sum2_q;
  logic ov_q;
  logic [W-1:0] res_q;
  logic [3:0] flg_q;
  logic sa, sb, sx, sy, za, zb, zx, zy, na, nb, ia, ib, swp, inv_d, spc_d;
  logic [EXP_W-1:0] ea, eb, ex, ey, dx;
  logic [MAN_W-1:0] ma, mb, mx, my;
  logic [F-1:0] fx, fy, fya;
  logic [2*F-1:0] sh;
  logic [W-1:0] sres_d;
  int dc;
  logic [N-1:0] sum_d;
  logic carry, zero, rnd_up, rc;
  logic [F-1:0] sl, m;
  logic [MAN_W-1:0] mant;
  int lz, ne, re;
  logic [W-1:0] res_d;
  logic [3:0] flg_d;
  assign en = !ov_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = ov_q;
  assign bus.result = res_q;
  assign bus.flags = flg_q;
  // S1: unpack, classify, order by magnitude, align the smaller significand
  always_comb begin
    sa = bus.a[W-1];
    sb = bus.b[W-1] ^ bus.op_sub;
    ea = bus.a[W-2:MAN_W];
    eb = bus.b[W-2:MAN_W];
    za = ea == '0;
    zb = eb == '0;
    // subnormals are flushed by masking their mantissa
    ma = bus.a[MAN_W-1:0] & {MAN_W{~za}};
    mb = bus.b[MAN_W-1:0] & {MAN_W{~zb}};
    na = &ea && |ma;
    nb = &eb && |mb;
    ia = &ea && ~|ma;
    ib = &eb && ~|mb;
    swp = {eb, mb} > {ea, ma};
    {sx, ex, mx, zx} = swp ? {sb, eb, mb, zb} : {sa, ea, ma, za};
    {sy, ey, my, zy} = swp ? {sa, ea, ma, za} : {sb, eb, mb, zb};
    fx = zx ? '0 : {1'b1, mx, 3'b000};
    fy = zy ? '0 : {1'b1, my, 3'b000};
    dx = ex - ey;
    dc = (int'(dx) > F) ? F : int'(dx);
    sh = {fy, {F{1'b0}}} >> dc;
    fya = sh[2*F-1:F] | {{(F-1){1'b0}}, |sh[F-1:0]};
    inv_d = (na || nb) ? ((na && !ma[MAN_W-1]) || (nb && !mb[MAN_W-1])) : (ia && ib && (sa ^ sb));
    spc_d = na || nb || ia || ib;
    sres_d = (na || nb || inv_d) ? QNAN : {ia ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end
  // S2: magnitude add/sub; x >= y so subtraction never goes negative
  assign sum_d = sub1_q ? {1'b0, fx1_q} - {1'b0, fy1_q} : {1'b0, fx1_q} + {1'b0, fy1_q};
  // S3: normalize, round to nearest even, pack
  always_comb begin
    lz = 0;
    for (int i = 0; i < F; i++)
      if (sum2_q[i]) lz = F - 1 - i;
    carry = sum2_q[N-1];
    sl = sum2_q[F-1:0] << lz;
    m = carry ? {sum2_q[N-1:2], |sum2_q[1:0]} : sl;
    zero = !m[F-1];
    rnd_up = m[2] && (m[1] || m[0] || m[3]);
    {rc, mant} = {1'b0, m[F-2:3]} + (MAN_W+1)'(rnd_up);
    ne = int'(e2_q) + (carry ? 1 : -lz);
    re = ne + int'(rc);
    res_d = {s2_q, EXP_W'(re), mant};
    flg_d = {3'b000, m[2] || m[1] || m[0]};
    if (spc2_q) begin
      res_d = sres2_q;
      flg_d = {inv2_q, 3'b000};
    end else if (zero) begin
      res_d = {s2_q && !sub2_q, {(W-1){1'b0}}};
      flg_d = 4'b0000;
    end else if (ne < 1) begin
      res_d = {s2_q, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if (re >= (1 << EXP_W) - 1) begin
      res_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1_q, spc1_q, inv1_q, s1_q, sub1_q, sres1_q, e1_q, fx1_q, fy1_q} <= '0;
      {v2_q, spc2_q, inv2_q, s2_q, sub2_q, sres2_q, e2_q, sum2_q} <= '0;
      {ov_q, res_q, flg_q} <= '0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      spc1_q <= spc_d;
      inv1_q <= inv_d;
      sres1_q <= sres_d;
      s1_q <= sx;
      sub1_q <= sx ^ sy;
      e1_q <= ex;
      fx1_q <= fx;
      fy1_q <= fya;
      v2_q <= v1_q;
      spc2_q <= spc1_q;
      inv2_q <= inv1_q;
      sres2_q <= sres1_q;
      s2_q <= s1_q;
      sub2_q <= sub1_q;
      e2_q <= e1_q;
      sum2_q <= sum_d;
      ov_q <= v2_q;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_mp64_fp_add_pipe.sv
// tb_mp64_fp_add_pipe: directed-vector scoreboard bench for FP32 and FP16 adder instances.
module tb_mp64_fp_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          acc;
    bit          timed;
  } item_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;
  item_t q32[$];
  item_t q16[$];
  vec_t v32 [14] = '{
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
    '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
    '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},
    '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011},
    '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},
    '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
    '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000},
    '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000}
  };
  vec_t vbp [6] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},
    '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000},
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},
    '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'b0000},
    '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000},
    '{32'h00000000, 32'h12345678, 1'b0, 32'h12345678, 4'b0000}
  };
  vec_t v16 [3] = '{
    '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000},
    '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101},
    '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'b0000}
  };
  logic        held = 1'b0;
  logic [31:0] hres;
  logic [3:0]  hflg;
  mp64_fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  mp64_fp_add_pipe_if #(.EXP_W(5), .MAN_W(10)) b16 ();
  mp64_fp_add_pipe #(.EXP_W(8), .MAN_W(23)) u32 (.clk(clk), .rst(rst), .bus(b32));
  mp64_fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u16 (.clk(clk), .rst(rst), .bus(b16));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input bit h, input vec_t v, input bit timed);
    item_t it;
    if (h) begin
      b16.a = v.a[15:0];
      b16.b = v.b[15:0];
      b16.op_sub = v.sub;
      b16.in_valid = 1'b1;
    end else begin
      b32.a = v.a;
      b32.b = v.b;
      b32.op_sub = v.sub;
      b32.in_valid = 1'b1;
    end
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((h ? b16.in_ready : b32.in_ready) === 1'b1) break;
      if (n == 999) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout h=%0d", h);
      end
    end
    it = '{v.r, v.f, cyc, timed};
    if (h) q16.push_back(it);
    else q32.push_back(it);
    @(posedge clk);
    #1;
    if (h) b16.in_valid = 1'b0;
    else b32.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && (q32.size() + q16.size()) != 0; n++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(q32.size() + q16.size()), 32'd0);
  endtask
  initial begin
    item_t it32, it16;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.op_sub = 1'b0; b32.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.op_sub = 1'b0; b16.out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (!rst && b32.out_valid) begin
          if (held) begin
            chk("hold_result", b32.result, hres);
            chk("hold_flags", 32'(b32.flags), 32'(hflg));
          end
          if (b32.out_ready) begin
            held = 1'b0;
            if (q32.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out32 got %h expected none", b32.result);
            end else begin
              it32 = q32.pop_front();
              chk("result32", b32.result, it32.r);
              chk("flags32", 32'(b32.flags), 32'(it32.f));
              if (it32.timed) chk("latency32", 32'(cyc), 32'(it32.acc + 3));
            end
          end else begin
            held = 1'b1;
            hres = b32.result;
            hflg = b32.flags;
          end
        end else held = 1'b0;
      end
      forever begin
        @(negedge clk);
        if (!rst && b16.out_valid && b16.out_ready) begin
          if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out16 got %h expected none", b16.result);
          end else begin
            it16 = q16.pop_front();
            chk("result16", 32'(b16.result), it16.r);
            chk("flags16", 32'(b16.flags), 32'(it16.f));
            if (it16.timed) chk("latency16", 32'(cyc), 32'(it16.acc + 3));
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(b32.out_valid), 32'd0);
    chk("rst_result", b32.result, 32'd0);
    chk("rst_flags", 32'(b32.flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(b32.in_ready), 32'd1);
    @(posedge clk);
    #1;
    foreach (v32[i]) issue(1'b0, v32[i], 1'b1);
    drain();
    fork
      foreach (vbp[i]) issue(1'b0, vbp[i], 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 b32.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (b32.out_valid) chk("in_ready_stall", 32'(b32.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 b32.out_ready = 1'b1;
      end
    join
    drain();
    b32.a = 32'h3F800000;
    b32.b = 32'h3F800000;
    b32.op_sub = 1'b0;
    b32.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 b32.in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(b32.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1 chk("async_rst_out_valid", 32'(b32.out_valid), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_out", 32'(b32.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000}, 1'b1);
    drain();
    foreach (v16[i]) issue(1'b1, v16[i], 1'b1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
